branch_prediction_queue: RTL and testbench

//  In-flight branch prediction buffer that sits directly upstream of branch_prediction_switch.

---
 rtl/branch_prediction_queue_if.sv | 35 +++
 rtl/branch_prediction_queue.sv | 127 ++++++++++++
 tb/tb_branch_prediction_queue.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/branch_prediction_queue_if.sv
// Handshake bundle between fetch/EX (master) and the in-flight branch prediction queue (slave).
interface branch_prediction_queue_if #(
  parameter int PTR_W = 2
);
  logic             flush;
  logic             push_valid;
  logic             push_ready;
  logic             push_local;
  logic             push_global;
  logic             push_switch;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             renew_valid;
  logic             renew_local_result;
  logic             renew_global_result;
  logic             renew_switch_result;
  logic             renew_result;
  logic             mispredict;
  logic             underflow;
  logic [PTR_W:0]   count;

  modport master (
    output flush, push_valid, push_local, push_global, push_switch,
           resolve_valid, resolve_taken,
    input  push_ready, renew_valid, renew_local_result, renew_global_result,
           renew_switch_result, renew_result, mispredict, underflow, count
  );

  modport slave (
    input  flush, push_valid, push_local, push_global, push_switch,
           resolve_valid, resolve_taken,
    output push_ready, renew_valid, renew_local_result, renew_global_result,
           renew_switch_result, renew_result, mispredict, underflow, count
  );
endinterface

// File: rtl/branch_prediction_queue.sv
// In-order queue of {local, global, switch} predictions; each resolution pops the head,
// emits a registered renew strobe for the chooser and squashes wrong-path entries on mispredict.
module branch_prediction_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  branch_prediction_queue_if.slave bus
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  // Entry layout: [2] = local, [1] = global, [0] = switch
  logic [2:0] entry_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             renew_valid_q, renew_valid_d;
  logic             renew_local_q, renew_local_d;
  logic             renew_global_q, renew_global_d;
  logic             renew_switch_q, renew_switch_d;
  logic             renew_result_q, renew_result_d;
  logic             mispredict_q, mispredict_d;
  logic             underflow_q, underflow_d;

  logic       push_ready;
  logic       push_fire;
  logic       pop_fire;
  logic       head_pred;
  logic       pop_mis;
  logic [2:0] head;

  assign push_ready = (count_q != FULL);
  assign push_fire  = bus.push_valid && push_ready && !bus.flush;
  assign pop_fire   = bus.resolve_valid && (count_q != '0) && !bus.flush;
  assign head       = entry_mem[rd_ptr_q];
  assign head_pred  = head[0] ? head[1] : head[2];
  assign pop_mis    = pop_fire && (head_pred != bus.resolve_taken);

  // Storage has no reset; stale slots are never read because count gates every pop.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      entry_mem[wr_ptr_q] <= {bus.push_local, bus.push_global, bus.push_switch};
    end
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    renew_valid_d  = 1'b0;
    renew_local_d  = renew_local_q;
    renew_global_d = renew_global_q;
    renew_switch_d = renew_switch_q;
    renew_result_d = renew_result_q;
    mispredict_d   = 1'b0;
    underflow_d    = 1'b0;

    if (bus.flush) begin
      wr_ptr_d = rd_ptr_q;
      count_d  = '0;
    end else begin
      underflow_d = bus.resolve_valid && (count_q == '0);
      if (pop_fire) begin
        renew_valid_d  = 1'b1;
        renew_local_d  = head[2];
        renew_global_d = head[1];
        renew_switch_d = head[0];
        renew_result_d = bus.resolve_taken;
        mispredict_d   = pop_mis;
      end
      if (pop_mis) begin
        // Everything younger than the mispredicted branch is wrong-path, including a same-cycle push.
        rd_ptr_d = rd_ptr_q + 1'b1;
        wr_ptr_d = rd_ptr_q + 1'b1;
        count_d  = '0;
      end else begin
        if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_fire, pop_fire})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      renew_valid_q  <= 1'b0;
      renew_local_q  <= 1'b0;
      renew_global_q <= 1'b0;
      renew_switch_q <= 1'b0;
      renew_result_q <= 1'b0;
      mispredict_q   <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      renew_valid_q  <= renew_valid_d;
      renew_local_q  <= renew_local_d;
      renew_global_q <= renew_global_d;
      renew_switch_q <= renew_switch_d;
      renew_result_q <= renew_result_d;
      mispredict_q   <= mispredict_d;
      underflow_q    <= underflow_d;
    end
  end

  assign bus.push_ready          = push_ready;
  assign bus.renew_valid         = renew_valid_q;
  assign bus.renew_local_result  = renew_local_q;
  assign bus.renew_global_result = renew_global_q;
  assign bus.renew_switch_result = renew_switch_q;
  assign bus.renew_result        = renew_result_q;
  assign bus.mispredict          = mispredict_q;
  assign bus.underflow           = underflow_q;
  assign bus.count               = count_q;

endmodule

// File: tb/tb_branch_prediction_queue.sv
// Directed bench for branch_prediction_queue: hand-computed expectations checked after each edge.
module tb_branch_prediction_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;

  branch_prediction_queue_if #(.PTR_W(PTR_W)) bus ();

  branch_prediction_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic l, input logic g, input logic s,
                       input logic rv, input logic rt, input logic fl);
    bus.push_valid    = pv;
    bus.push_local    = l;
    bus.push_global   = g;
    bus.push_switch   = s;
    bus.resolve_valid = rv;
    bus.resolve_taken = rt;
    bus.flush         = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks a renew strobe: {local, global, switch, result, mispredict}
  task automatic chk_renew(input string tag, input logic [4:0] exp);
    chk({tag, "_rv"}, 32'(bus.renew_valid), 32'd1);
    chk({tag, "_fields"}, 32'({bus.renew_local_result, bus.renew_global_result,
                                bus.renew_switch_result, bus.renew_result, bus.mispredict}),
        32'(exp));
  endtask

  initial begin
    logic [2:0] e;
    logic       pred;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_ready", 32'(bus.push_ready), 32'd1);
    chk("reset_outs", 32'({bus.renew_valid, bus.renew_local_result, bus.renew_global_result,
                           bus.renew_switch_result, bus.renew_result, bus.mispredict,
                           bus.underflow}), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single push then correct resolve
    drive(1, 1, 0, 0, 0, 0, 0); tick();
    chk("t1_count_push", 32'(bus.count), 32'd1);
    chk("t1_no_renew", 32'(bus.renew_valid), 32'd0);
    drive(0, 0, 0, 0, 1, 1, 0); tick();
    chk_renew("t1_renew", 5'b10010);
    chk("t1_count_pop", 32'(bus.count), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk("t1_rv_pulse", 32'(bus.renew_valid), 32'd0);
    chk("t1_hold_local", 32'(bus.renew_local_result), 32'd1);

    // 2: fill to DEPTH, blocked push, pop-only while full, drain
    drive(1, 0, 1, 1, 0, 0, 0); tick();
    drive(1, 1, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 0, 0, 0); tick();
    chk("t2_count3", 32'(bus.count), 32'd3);
    drive(1, 1, 0, 1, 0, 0, 0); tick();
    chk("t2_count4", 32'(bus.count), 32'd4);
    chk("t2_ready_full", 32'(bus.push_ready), 32'd0);
    drive(1, 1, 1, 1, 0, 0, 0); tick();
    chk("t2_fifth_blocked", 32'(bus.count), 32'd4);
    drive(1, 1, 1, 1, 1, 1, 0); tick();
    chk_renew("t2_pop_full", 5'b01110);
    chk("t2_pop_only", 32'(bus.count), 32'd3);
    chk("t2_ready_again", 32'(bus.push_ready), 32'd1);
    drive(0, 0, 0, 0, 1, 1, 0); tick();
    chk_renew("t2_drain1", 5'b11010);
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    chk_renew("t2_drain2", 5'b00100);
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    chk_renew("t2_drain3", 5'b10100);
    chk("t2_empty", 32'(bus.count), 32'd0);

    // 3: mispredict flushes younger entries and a same-cycle push
    drive(1, 0, 1, 1, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 1, 1, 0, 0, 0); tick();
    chk("t3_count3", 32'(bus.count), 32'd3);
    drive(1, 1, 1, 1, 1, 0, 0); tick();
    chk_renew("t3_mis", 5'b01101);
    chk("t3_count0", 32'(bus.count), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk("t3_mis_pulse", 32'({bus.renew_valid, bus.mispredict}), 32'd0);
    chk("t3_still_empty", 32'(bus.count), 32'd0);

    // 4: underflow, then underflow with accepted push
    drive(0, 0, 0, 0, 1, 1, 0); tick();
    chk("t4_underflow", 32'({bus.underflow, bus.renew_valid}), 32'b10);
    chk("t4_uf_count", 32'(bus.count), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk("t4_uf_pulse", 32'(bus.underflow), 32'd0);
    drive(1, 1, 0, 1, 1, 1, 0); tick();
    chk("t4_uf_push", 32'({bus.underflow, bus.renew_valid}), 32'b10);
    chk("t4_uf_push_count", 32'(bus.count), 32'd1);
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    chk_renew("t4_pop", 5'b10100);
    chk("t4_uf_clear", 32'(bus.underflow), 32'd0);

    // 5: flush beats resolve and push
    drive(1, 1, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    chk("t5_count2", 32'(bus.count), 32'd2);
    drive(1, 1, 1, 1, 1, 0, 1); tick();
    chk("t5_flush_count", 32'(bus.count), 32'd0);
    chk("t5_flush_outs", 32'({bus.renew_valid, bus.mispredict, bus.underflow}), 32'd0);
    drive(1, 0, 1, 0, 0, 0, 0); tick();
    chk("t5_push_after", 32'(bus.count), 32'd1);
    drive(0, 0, 0, 0, 1, 1, 0); tick();
    chk_renew("t5_resolve_after", 5'b01011);
    chk("t5_count_end", 32'(bus.count), 32'd0);

    // 6: overlapped push/pop stream across several pointer wraps
    drive(1, 1'b0, 1'b0, 1'b0, 0, 0, 0); tick();
    for (int i = 1; i <= 2*DEPTH + 1; i++) begin
      e    = 3'(i - 1);
      pred = e[0] ? e[1] : e[2];
      drive(i <= 2*DEPTH, i[2], i[1], i[0], 1, pred, 0);
      tick();
      chk($sformatf("t6_renew%0d", i - 1), 32'({bus.renew_valid, bus.renew_local_result,
          bus.renew_global_result, bus.renew_switch_result, bus.renew_result, bus.mispredict}),
          32'({1'b1, e[2], e[1], e[0], pred, 1'b0}));
      chk($sformatf("t6_count%0d", i - 1), 32'(bus.count), (i <= 2*DEPTH) ? 32'd1 : 32'd0);
    end
    drive(1, 1, 1, 1, 0, 0, 0); tick();
    drive(1, 0, 1, 0, 0, 0, 0); tick();
    chk("t6_pre_reset", 32'(bus.count), 32'd2);
    drive(0, 0, 0, 0, 1, 1, 0); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_count", 32'(bus.count), 32'd0);
    chk("t6_async_outs", 32'({bus.renew_valid, bus.renew_local_result, bus.renew_global_result,
                              bus.renew_switch_result, bus.renew_result, bus.mispredict,
                              bus.underflow}), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("t6_post_reset", 32'(bus.count), 32'd0);
    drive(0, 0, 0, 0, 1, 1, 0); tick();
    chk("t6_post_uf", 32'({bus.underflow, bus.renew_valid}), 32'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
